// File: rtl/angle_ctrl_seq.sv
// angle_ctrl_seq: pipeline enable sequencer (IDLE -> SETTLE -> FILL -> RUN).
// Optional feature macro ANGLE_CTRL_DRAIN_EN: an accepted restart drains
// the enables one stage per cycle (DRAIN) instead of clearing them at once.
module angle_ctrl_seq #(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned LOOP_LEN   = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic                  hold,
    output logic [NUM_STAGES-1:0] en,
    output logic                  loop_last,
    output logic [CNT_W-1:0]      iter_cnt,
    output logic                  busy
);

    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned PH_W  = $clog2(LOOP_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(LOOP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        FILL   = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [PH_W-1:0]  phase, phase_n;
    logic [IDX_W-1:0] idx, idx_n;
    // Cleared by reset so IDLE spans the first cycle after reset release.
    logic             armed;

    logic [NUM_STAGES-1:0] en_n;
    logic [CNT_W-1:0]      iter_n;
    logic                  loop_last_n;
    logic                  busy_n;

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            idx       <= '0;
            armed     <= 1'b0;
            en        <= '0;
            loop_last <= 1'b0;
            iter_cnt  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            idx       <= idx_n;
            armed     <= 1'b1;
            en        <= en_n;
            loop_last <= loop_last_n;
            iter_cnt  <= iter_n;
            busy      <= busy_n;
        end
    end

    // Next state, RUN phase and fill/drain index; hold freezes FILL/RUN/DRAIN.
    always_comb begin
        state_n = state;
        phase_n = phase;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (armed) state_n = SETTLE;
            end
            SETTLE: begin
                state_n = FILL;
                idx_n   = '0;
            end
            FILL: begin
                if (!hold) begin
                    if (idx == IDX_LAST) begin
                        state_n = RUN;
                        phase_n = '0;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            RUN: begin
                if (!hold) begin
                    if (phase == PH_LAST) begin
                        phase_n = '0;
                        if (restart) begin
`ifdef ANGLE_CTRL_DRAIN_EN
                            state_n = DRAIN;
                            idx_n   = '0;
`else
                            state_n = IDLE;
`endif
                        end
                    end else begin
                        phase_n = phase + PH_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!hold) begin
                    if (idx == IDX_LAST) begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        en_n   = en;
        iter_n = iter_cnt;
        case (state)
            IDLE: begin
                en_n   = '0;
                iter_n = '0;
            end
            FILL: begin
                if (!hold) en_n[idx] = 1'b1;
            end
            RUN: begin
                if (!hold && (phase == PH_LAST)) begin
                    if (restart) begin
`ifdef ANGLE_CTRL_DRAIN_EN
                        iter_n = iter_cnt;
`else
                        en_n   = '0;
                        iter_n = '0;
`endif
                    end else if (iter_cnt != CNT_MAX) begin
                        iter_n = iter_cnt + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!hold) begin
                    en_n[idx] = 1'b0;
                    if (idx == IDX_LAST) iter_n = '0;
                end
            end
            default: begin
                en_n = en;
            end
        endcase
        loop_last_n = (state_n == RUN) && (phase_n == PH_LAST);
        busy_n      = (state_n == FILL) || (state_n == DRAIN);
    end

endmodule

// File: tb/tb_angle_ctrl_seq.sv
// Bench for angle_ctrl_seq (NUM_STAGES=4, LOOP_LEN=5, CNT_W=2).
// The model tracks progress as a step count since the last IDLE entry and
// derives every output arithmetically from it.
module tb_angle_ctrl_seq;

    localparam int NS   = 4;
    localparam int LL   = 5;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int ALL  = (1 << NS) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          restart = 1'b0;
    logic          hold = 1'b0;
    logic [NS-1:0] en;
    logic          loop_last;
    logic [CW-1:0] iter_cnt;
    logic          busy;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model: step -1 = in reset, 0 = IDLE, 1 = SETTLE, 2.. = FILL then RUN.
    int step  = -1;
    bit drn   = 1'b0;
    int d     = 0;
    int fiter = 0;

    always #5 clk = ~clk;

    angle_ctrl_seq #(.NUM_STAGES(NS), .LOOP_LEN(LL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .hold(hold),
        .en(en), .loop_last(loop_last), .iter_cnt(iter_cnt), .busy(busy)
    );

    function automatic int m_iter();
        int r;
        if (drn) return fiter;
        if (step < 2 + NS) return 0;
        r = (step - 2 - NS) / LL;
        return (r > CMAX) ? CMAX : r;
    endfunction

    function automatic int m_en();
        if (drn) return ALL & ~((1 << d) - 1);
        if (step < 2) return 0;
        if (step < 2 + NS) return (1 << (step - 2)) - 1;
        return ALL;
    endfunction

    function automatic int m_ll();
        if (drn || step < 2 + NS) return 0;
        return (((step - 2 - NS) % LL) == LL - 1) ? 1 : 0;
    endfunction

    function automatic int m_busy();
        return (drn || (step >= 2 && step < 2 + NS)) ? 1 : 0;
    endfunction

    // Advance the model on each rising edge from the inputs it sampled.
    always @(posedge clk) begin
        if (!rst_n) begin
            step = -1;
            drn  = 1'b0;
            d    = 0;
        end else if (drn) begin
            if (!hold) begin
                if (d == NS - 1) begin
                    drn  = 1'b0;
                    step = 0;
                end else begin
                    d = d + 1;
                end
            end
        end else if (step < 2) begin
            step = step + 1;
        end else if (!hold) begin
            if (m_ll() == 1 && restart) begin
`ifdef ANGLE_CTRL_DRAIN_EN
                fiter = m_iter();
                drn   = 1'b1;
                d     = 0;
`else
                step  = 0;
`endif
            end else begin
                step = step + 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_en", int'(en), m_en());
            chk("m_loop_last", int'(loop_last), m_ll());
            chk("m_iter_cnt", int'(iter_cnt), m_iter());
            chk("m_busy", int'(busy), m_busy());
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk_on = 1'b1;
        chk("rst_en", int'(en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_iter", int'(iter_cnt), 0);
        chk("rst_ll", int'(loop_last), 0);

        // Release reset: edges 0..6 fill the pipeline.
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("e2_en", int'(en), 0);
        chk("e2_busy", int'(busy), 1);
        tick();
        chk("e3_en", int'(en), 1);
        tick();
        chk("e4_en", int'(en), 3);
        tick(); tick();
        chk("e6_en", int'(en), 15);
        chk("e6_busy", int'(busy), 0);

        // Restart pulsed at phase 2 is ignored.
        tick(); tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("pulse_en", int'(en), 15);
        tick();
        chk("e10_ll", int'(loop_last), 1);
        chk("e10_iter", int'(iter_cnt), 0);
        tick();
        chk("e11_iter", int'(iter_cnt), 1);
        chk("e11_ll", int'(loop_last), 0);

        // Counter saturates at 3.
        repeat (25) tick();
        chk("sat_iter", int'(iter_cnt), 3);

        // Hold and restart together at loop end: stays in RUN.
        n = 0;
        while (m_ll() == 0 && n < 20) begin tick(); n++; end
        chk("wait_ll", n < 20 ? 1 : 0, 1);
        hold = 1'b1;
        restart = 1'b1;
        tick(); tick();
        chk("hold_en", int'(en), 15);
        chk("hold_ll", int'(loop_last), 1);
        chk("hold_busy", int'(busy), 0);
        hold = 1'b0;
        tick();
`ifdef ANGLE_CTRL_DRAIN_EN
        chk("acc_en", int'(en), 15);
        chk("acc_busy", int'(busy), 1);
        tick();
        chk("dr1_en", int'(en), 14);
        tick();
        chk("dr2_en", int'(en), 12);
        tick();
        chk("dr3_en", int'(en), 8);
        chk("dr3_busy", int'(busy), 1);
        tick();
        chk("dr4_en", int'(en), 0);
        chk("dr4_busy", int'(busy), 0);
`else
        chk("acc_en", int'(en), 0);
        chk("acc_busy", int'(busy), 0);
        chk("acc_iter", int'(iter_cnt), 0);
`endif
        restart = 1'b0;

        // Hold three cycles mid-FILL at en=0011.
        n = 0;
        while (!(!drn && step == 4) && n < 30) begin tick(); n++; end
        chk("wait_fill", n < 30 ? 1 : 0, 1);
        hold = 1'b1;
        repeat (3) begin
            tick();
            chk("fhold_en", int'(en), 3);
            chk("fhold_busy", int'(busy), 1);
        end
        hold = 1'b0;
        tick();
        chk("fresume_en", int'(en), 7);
        chk("fresume_iter", int'(iter_cnt), 0);

        // Reset for one edge mid-RUN, hold ignored in IDLE/SETTLE afterwards.
        repeat (12) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_en", int'(en), 0);
        chk("mrst_iter", int'(iter_cnt), 0);
        chk("mrst_busy", int'(busy), 0);
        rst_n = 1'b1;
        hold = 1'b1;
        tick(); tick();
        hold = 1'b0;
        tick();
        chk("rf2_en", int'(en), 0);
        chk("rf2_busy", int'(busy), 1);
        tick();
        chk("rf3_en", int'(en), 1);
        repeat (20) tick();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/angle_ctrl_seq.md
ANGLE_CTRL_SEQ -- requirements
Module: angle_ctrl_seq

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2, number of pipeline enable outputs (legal 1..8).
REQ-002 SHALL have parameter LOOP_LEN, default 2, cycles per steady-state iteration (legal 2..16).
REQ-003 SHALL have parameter CNT_W, default 4, width of iteration counter.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 restart  input  1  level request to return to IDLE, sampled only at loop end.
REQ-007 hold  input  1  freeze request, level.
REQ-008 en  output  NUM_STAGES  registered stage enables; en[0] is first stage.
REQ-009 loop_last  output  1  registered, high during the last RUN cycle of each iteration.
REQ-010 iter_cnt  output  CNT_W  registered count of completed RUN iterations.
REQ-011 busy  output  1  registered, high while in FILL or DRAIN.

Function
REQ-012 States SHALL be IDLE, SETTLE, FILL, RUN, DRAIN (DRAIN only per REQ-026); edge 0 = first rising edge with rst_n sampled high.
REQ-013 IDLE SHALL last one cycle with en=0, then go to SETTLE; SETTLE SHALL last one cycle with en=0, then go to FILL with fill index 0.
REQ-014 FILL SHALL set en[fill index] each cycle, cumulatively, index incrementing; en[k] rises at edge k+3 after reset release absent hold.
REQ-015 After en[NUM_STAGES-1] is set, state SHALL be RUN with phase 0 and all en high; NUM_STAGES=1 gives a one-cycle FILL.
REQ-016 RUN phase SHALL count 0..LOOP_LEN-1 and wrap to 0; loop_last high exactly when phase = LOOP_LEN-1.
REQ-017 restart SHALL be acted on only when phase = LOOP_LEN-1 and hold low; otherwise ignored (not latched).
REQ-018 At each RUN wrap without restart, iter_cnt SHALL increment, saturating at 2^CNT_W-1.
REQ-019 iter_cnt SHALL clear on entry to IDLE.
REQ-020 hold high in FILL, RUN or DRAIN SHALL freeze state, phase, fill/drain index, iter_cnt and en (en held, not cleared); loop_last held at its value.
REQ-021 hold SHALL be ignored in IDLE and SETTLE.
REQ-022 hold and restart both high at loop end: hold wins, restart ignored that cycle.
REQ-023 busy SHALL equal (state is FILL or DRAIN), updated with state.

Reset
REQ-024 rst_n low at a rising edge SHALL force state IDLE, en=0, loop_last=0, iter_cnt=0, busy=0, all indices 0, regardless of current state, including mid-FILL, mid-RUN or mid-DRAIN.
REQ-025 No output SHALL change asynchronously to clk.

Configuration
REQ-026 Macro ANGLE_CTRL_DRAIN_EN defined: restart accepted in RUN SHALL enter DRAIN, clearing en[0], en[1], ... one per cycle (en[k] falls k+1 edges after acceptance), then IDLE after en[NUM_STAGES-1] clears; restart ignored during DRAIN; iter_cnt not incremented on the accepting edge.
REQ-027 Macro undefined: restart accepted in RUN SHALL clear all en at the accepting edge and enter IDLE; DRAIN absent, busy high only in FILL.

Verification
REQ-028 Defaults, release reset, restart=0, hold=0 -> en=00 edges 0-2, en=01 edge 3, en=11 edge 4, loop_last toggles every cycle after, iter_cnt 1,2,3... every 2 cycles.
REQ-029 NUM_STAGES=4, LOOP_LEN=5, restart pulsed for one cycle at phase 2 -> ignored, en stays 1111, iter_cnt keeps counting.
REQ-030 NUM_STAGES=4, restart held high across loop end, macro defined -> en 1110,1100,1000,0000 on consecutive edges, busy high 4 cycles, then IDLE, SETTLE, refill 0001..1111, iter_cnt restarts from 0; macro undefined -> en 0000 at one edge.
REQ-031 hold high 3 cycles mid-FILL (en=0011, NUM_STAGES=4) -> en, busy frozen 3 cycles, then fill resumes with 0111; hold and restart both high at loop end -> remains RUN.
REQ-032 CNT_W=2, run 6 iterations -> iter_cnt 1,2,3,3,3,3; rst_n low for one edge mid-RUN -> all outputs 0 next cycle, refill per REQ-014.
